aftab_csr_write_sequencer: RTL and testbench

Sequences CSR write transactions into the AFTAB CSR register bank, including the read-modify-write update of the machine-level register whenever a user-level mirrored CSR (ustatus, uie, uip) is written. It sits directly downstream of the CSR address decode logic, consuming its mirror flags. It drives the bank's address, write-data and write-enable lines, and reports busy/done to the controller.

---
 rtl/aftab_csr_write_sequencer.sv | 145 ++++++++++++++
 tb/tb_aftab_csr_write_sequencer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/aftab_csr_write_sequencer.sv
// AFTAB CSR write sequencer: primary write plus read-modify-write of the
// machine-level mirror of ustatus/uie/uip. Mirror path gated by AFTAB_CSR_MIRROR_EN.
module aftab_csr_write_sequencer #(
    parameter logic [31:0] USER_STATUS_MASK = 32'h0000_0011,
    parameter logic [31:0] USER_INT_MASK    = 32'h0000_0111
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        startWrite,
    input  logic [11:0] csrAddress,
    input  logic [31:0] writeData,
    input  logic        mirror,
    input  logic        mirrorUstatus,
    input  logic        mirrorUie,
    input  logic        mirrorUip,
    input  logic [31:0] csrBankRdData,
    output logic [11:0] csrBankAddr,
    output logic [31:0] csrBankWrData,
    output logic        csrBankWrEn,
    output logic        busy,
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_PRIMARY,
        S_RD_MIRROR,
        S_MERGE_WR,
        S_DONE
    } state_t;

    state_t      state_q;
    logic [11:0] addr_q;
    logic [31:0] data_q;
    logic        mirror_q;
    logic        ust_q;
    logic        uie_q;
    logic        uip_q;
    logic [11:0] bank_addr_q;
    logic        wr_en_q;
    logic        busy_q;
    logic        done_q;

    logic        take_mirror;
    logic [11:0] mirror_addr;
    logic [31:0] mask;
    logic [31:0] merge_data;

`ifdef AFTAB_CSR_MIRROR_EN
    // Only the user-level page (0x0xx) has a machine-level shadow.
    assign take_mirror = mirror_q && (addr_q[11:8] == 4'h0);
    assign mirror_addr = {4'h3, addr_q[7:0]};

    always_comb begin
        mask = 32'h0;
        if (ust_q)
            mask = USER_STATUS_MASK;
        else if (uie_q || uip_q)
            mask = USER_INT_MASK;
    end

    assign merge_data = (csrBankRdData & ~mask) | (data_q & mask);
    assign csrBankWrData = (state_q == S_MERGE_WR) ? merge_data : data_q;
`else
    logic unused_mirror_path;

    assign take_mirror   = 1'b0;
    assign mirror_addr   = 12'h000;
    assign mask          = 32'h0;
    assign merge_data    = 32'h0;
    assign csrBankWrData = data_q;
    assign unused_mirror_path = ^{USER_STATUS_MASK, USER_INT_MASK,
                                  csrBankRdData, addr_q, mirror_q,
                                  ust_q, uie_q, uip_q, take_mirror,
                                  mirror_addr, mask, merge_data};
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            addr_q      <= 12'h000;
            data_q      <= 32'h0;
            mirror_q    <= 1'b0;
            ust_q       <= 1'b0;
            uie_q       <= 1'b0;
            uip_q       <= 1'b0;
            bank_addr_q <= 12'h000;
            wr_en_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            done_q  <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (startWrite) begin
                        addr_q      <= csrAddress;
                        data_q      <= writeData;
                        mirror_q    <= mirror;
                        ust_q       <= mirrorUstatus;
                        uie_q       <= mirrorUie;
                        uip_q       <= mirrorUip;
                        bank_addr_q <= csrAddress;
                        wr_en_q     <= 1'b1;
                        busy_q      <= 1'b1;
                        state_q     <= S_WR_PRIMARY;
                    end
                end
                S_WR_PRIMARY: begin
                    if (take_mirror) begin
                        bank_addr_q <= mirror_addr;
                        state_q     <= S_RD_MIRROR;
                    end else begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
`ifdef AFTAB_CSR_MIRROR_EN
                S_RD_MIRROR: begin
                    wr_en_q <= 1'b1;
                    state_q <= S_MERGE_WR;
                end
                S_MERGE_WR: begin
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
`endif
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign csrBankAddr = bank_addr_q;
    assign csrBankWrEn = wr_en_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_aftab_csr_write_sequencer.sv
// Directed bench for aftab_csr_write_sequencer with a small CSR bank model.
// Expectations follow the mirror build when AFTAB_CSR_MIRROR_EN is defined.
module tb_aftab_csr_write_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        startWrite;
    logic [11:0] csrAddress;
    logic [31:0] writeData;
    logic        mirror;
    logic        mirrorUstatus;
    logic        mirrorUie;
    logic        mirrorUip;
    logic [31:0] csrBankRdData;
    logic [11:0] csrBankAddr;
    logic [31:0] csrBankWrData;
    logic        csrBankWrEn;
    logic        busy;
    logic        done;

    logic [31:0] bank [0:4095];
    int total = 0;
    int bad = 0;
    int n_done;
    int n_wr;

    aftab_csr_write_sequencer dut (
        .clk(clk),
        .rst(rst),
        .startWrite(startWrite),
        .csrAddress(csrAddress),
        .writeData(writeData),
        .mirror(mirror),
        .mirrorUstatus(mirrorUstatus),
        .mirrorUie(mirrorUie),
        .mirrorUip(mirrorUip),
        .csrBankRdData(csrBankRdData),
        .csrBankAddr(csrBankAddr),
        .csrBankWrData(csrBankWrData),
        .csrBankWrEn(csrBankWrEn),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // Bank: registered read, so data appears the cycle after the address.
    always @(posedge clk) begin
        csrBankRdData <= bank[csrBankAddr];
        if (csrBankWrEn)
            bank[csrBankAddr] <= csrBankWrData;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic req(input logic [11:0] a, input logic [31:0] d,
                       input logic m, input logic us, input logic ie,
                       input logic ip);
        startWrite    = 1'b1;
        csrAddress    = a;
        writeData     = d;
        mirror        = m;
        mirrorUstatus = us;
        mirrorUie     = ie;
        mirrorUip     = ip;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++)
            bank[i] = 32'h0;
        bank[12'h300] = 32'h0000_1888;
        bank[12'h304] = 32'h0000_0999;
        bank[12'h344] = 32'hFFFF_FFFF;
        csrBankRdData = 32'h0;
        rst = 1'b1;
        req(12'h000, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
        startWrite = 1'b0;

        // reset
        step();
        step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_wren", csrBankWrEn, 0);
        chk("rst_addr", csrBankAddr, 0);
        chk("rst_wdata", csrBankWrData, 0);
        rst = 1'b0;
        step();

        // plain write, then back-to-back request in the cycle after done
        req(12'h305, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        startWrite = 1'b0;
        chk("plain_c1_wren", csrBankWrEn, 1);
        chk("plain_c1_addr", csrBankAddr, 32'h305);
        chk("plain_c1_wdata", csrBankWrData, 32'hDEAD_BEEF);
        chk("plain_c1_busy", busy, 1);
        chk("plain_c1_done", done, 0);
        step();
        chk("plain_c2_done", done, 1);
        chk("plain_c2_wren", csrBankWrEn, 0);
        step();
        chk("plain_c3_busy", busy, 0);
        chk("plain_c3_done", done, 0);
        chk("plain_bank", bank[12'h305], 32'hDEAD_BEEF);
        req(12'h341, 32'h1234_5678, 1'b0, 1'b0, 1'b0, 1'b0);
        step();
        startWrite = 1'b0;
        chk("b2b_wren", csrBankWrEn, 1);
        chk("b2b_addr", csrBankAddr, 32'h341);
        chk("b2b_wdata", csrBankWrData, 32'h1234_5678);
        step();
        chk("b2b_done", done, 1);
        step();

        // ustatus mirror
        req(12'h000, 32'hFFFF_FFFF, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        startWrite = 1'b0;
        chk("ust_c1_wren", csrBankWrEn, 1);
        chk("ust_c1_addr", csrBankAddr, 32'h000);
        chk("ust_c1_wdata", csrBankWrData, 32'hFFFF_FFFF);
        step();
`ifdef AFTAB_CSR_MIRROR_EN
        chk("ust_c2_wren", csrBankWrEn, 0);
        chk("ust_c2_addr", csrBankAddr, 32'h300);
        chk("ust_c2_busy", busy, 1);
        chk("ust_c2_done", done, 0);
        step();
        chk("ust_c3_wren", csrBankWrEn, 1);
        chk("ust_c3_addr", csrBankAddr, 32'h300);
        chk("ust_c3_wdata", csrBankWrData, 32'h0000_1899);
        step();
        chk("ust_c4_done", done, 1);
        chk("ust_c4_wren", csrBankWrEn, 0);
        step();
        chk("ust_idle", busy, 0);
        chk("ust_bank300", bank[12'h300], 32'h0000_1899);
`else
        chk("ust_c2_done", done, 1);
        chk("ust_c2_wren", csrBankWrEn, 0);
        step();
        chk("ust_idle", busy, 0);
        chk("ust_bank300", bank[12'h300], 32'h0000_1888);
`endif
        chk("ust_bank000", bank[12'h000], 32'hFFFF_FFFF);

        // uie mirror
        req(12'h004, 32'h0, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        startWrite = 1'b0;
        chk("uie_c1_addr", csrBankAddr, 32'h004);
        step();
`ifdef AFTAB_CSR_MIRROR_EN
        step();
        chk("uie_c3_wren", csrBankWrEn, 1);
        chk("uie_c3_addr", csrBankAddr, 32'h304);
        chk("uie_c3_wdata", csrBankWrData, 32'h0000_0888);
        step();
        chk("uie_c4_done", done, 1);
        step();
        chk("uie_bank304", bank[12'h304], 32'h0000_0888);
`else
        chk("uie_c2_done", done, 1);
        step();
        chk("uie_bank304", bank[12'h304], 32'h0000_0999);
`endif

        // ustatus flag wins over uie when both are set
        req(12'h044, 32'h0, 1'b1, 1'b1, 1'b1, 1'b0);
        step();
        startWrite = 1'b0;
        step();
`ifdef AFTAB_CSR_MIRROR_EN
        step();
        chk("prio_c3_addr", csrBankAddr, 32'h344);
        chk("prio_c3_wdata", csrBankWrData, 32'hFFFF_FFEE);
        step();
        step();
        chk("prio_bank344", bank[12'h344], 32'hFFFF_FFEE);
`else
        step();
        chk("prio_bank344", bank[12'h344], 32'hFFFF_FFFF);
`endif

        // mirror flag on a non-user page is not taken
        req(12'h100, 32'hA5A5_A5A5, 1'b1, 1'b1, 1'b0, 1'b0);
        step();
        startWrite = 1'b0;
        step();
        chk("page_c2_done", done, 1);
        chk("page_c2_wren", csrBankWrEn, 0);
        step();
        chk("page_idle", busy, 0);

        // startWrite held through cycles 1-2 is ignored
        n_done = 0;
        n_wr   = 0;
        req(12'h000, 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 8; i++) begin
            step();
            if (done)
                n_done++;
            if (csrBankWrEn)
                n_wr++;
            if (i == 2)
                startWrite = 1'b0;
        end
        chk("ign_done_cnt", n_done, 1);
`ifdef AFTAB_CSR_MIRROR_EN
        chk("ign_wr_cnt", n_wr, 2);
`else
        chk("ign_wr_cnt", n_wr, 1);
`endif
        chk("ign_idle", busy, 0);

        // reset in cycle 2 aborts the transaction
        bank[12'h304] = 32'h0000_0888;
        req(12'h004, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0);
        step();
        startWrite = 1'b0;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_c3_wren", csrBankWrEn, 0);
        chk("abort_c3_busy", busy, 0);
        chk("abort_c3_done", done, 0);
        chk("abort_c3_addr", csrBankAddr, 0);
        step();
        step();
        chk("abort_c5_busy", busy, 0);
        chk("abort_c5_done", done, 0);
        chk("abort_bank304", bank[12'h304], 32'h0000_0888);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
